// File: rtl/fnd_scan_driver.sv
// Scans a latched 4-digit BCD value onto a common-anode FND with a blank gap between digit slots.
// Latency: outputs are registered one cycle behind the slot counter; digit data is snapshotted at the end of BLANK.
// Backpressure: none; loads are accepted on any cycle, including while the display is off.
module fnd_scan_driver #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1_000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          LZ_BLANK     = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_onOff,
    output logic [3:0]  o_digitPosition,
    output logic [7:0]  o_fndFont,
    output logic        o_frameTick
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SNAP  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DRIVE = CNT_W'(BLANK_CYCLES);

    logic [15:0]      valueReg;
    logic [3:0]       dpReg;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       index;

    logic [3:0]       snapNib;
    logic             snapDp;
    logic             snapBlank;

    logic [CNT_W-1:0] cntNext;
    logic [1:0]       indexNext;
    logic [3:0]       posNext;
    logic [7:0]       fontNext;
    logic             tickNext;
    logic             snapTake;
    logic             lzBlank;
    logic [3:0]       curNib;

    function automatic logic [7:0] fontOf(input logic [3:0] nib,
                                          input logic       dp,
                                          input logic       blank);
        logic [7:0] f;
        case (nib)
            4'd0:    f = 8'hC0;
            4'd1:    f = 8'hF9;
            4'd2:    f = 8'hA4;
            4'd3:    f = 8'hB0;
            4'd4:    f = 8'h99;
            4'd5:    f = 8'h92;
            4'd6:    f = 8'h82;
            4'd7:    f = 8'hF8;
            4'd8:    f = 8'h80;
            4'd9:    f = 8'h90;
            default: f = 8'hBF;
        endcase
        if (blank) begin
            f = 8'hFF;
        end
        // dp survives leading-zero blanking
        f[7] = ~dp;
        return f;
    endfunction

    // Leading-zero test for the digit about to be snapshotted; digit 0 always shows.
    always_comb begin
        lzBlank = 1'b0;
        case (index)
            2'd1:    lzBlank = (valueReg[15:4]  == 12'd0);
            2'd2:    lzBlank = (valueReg[15:8]  == 8'd0);
            2'd3:    lzBlank = (valueReg[15:12] == 4'd0);
            default: lzBlank = 1'b0;
        endcase
        if (!LZ_BLANK) begin
            lzBlank = 1'b0;
        end
    end

    assign curNib = valueReg[{index, 2'b00} +: 4];

    always_comb begin
        cntNext   = cnt;
        indexNext = index;
        posNext   = 4'b1111;
        fontNext  = 8'hFF;
        tickNext  = 1'b0;
        snapTake  = 1'b0;

        if (i_onOff) begin
            if (cnt == CNT_LAST) begin
                cntNext   = '0;
                indexNext = index + 2'd1;
                tickNext  = (index == 2'd3);
            end else begin
                cntNext = cnt + 1'b1;
            end

            snapTake = (cnt == CNT_SNAP);

            if (cnt >= CNT_DRIVE) begin
                posNext  = ~(4'b0001 << index);
                fontNext = fontOf(snapNib, snapDp, snapBlank);
            end
        end else begin
            cntNext   = '0;
            indexNext = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            valueReg        <= '0;
            dpReg           <= '0;
            cnt             <= '0;
            index           <= '0;
            snapNib         <= '0;
            snapDp          <= 1'b0;
            snapBlank       <= 1'b0;
            o_digitPosition <= 4'b1111;
            o_fndFont       <= 8'hFF;
            o_frameTick     <= 1'b0;
        end else begin
            if (i_load) begin
                valueReg <= i_value;
                dpReg    <= i_dp;
            end
            // Snapshot reads the pre-load registers, so a coincident load lands next slot.
            if (snapTake) begin
                snapNib   <= curNib;
                snapDp    <= dpReg[index];
                snapBlank <= lzBlank;
            end
            cnt             <= cntNext;
            index           <= indexNext;
            o_digitPosition <= posNext;
            o_fndFont       <= fontNext;
            o_frameTick     <= tickNext;
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Randomized and directed bench for fnd_scan_driver against a slot-level reference model.
module tb_fnd_scan_driver;

    logic        clk = 1'b0;
    logic        rstN;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        onOff;
    logic [3:0]  oPos;
    logic [7:0]  oFont;
    logic        oTick;

    int nCmp = 0;
    int nErr = 0;

    // Reference model state: k = edges since scan (re)start.
    int          k;
    logic [15:0] mVal;
    logic [3:0]  mDp;
    logic [15:0] sVal;
    logic [3:0]  sDp;
    logic [3:0]  expPos;
    logic [7:0]  expFont;
    logic        expTick;
    logic [7:0]  lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_scan_driver #(
        .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2), .LZ_BLANK(1'b1)
    ) dut (
        .i_clk(clk), .i_reset(rstN), .i_load(load), .i_value(value), .i_dp(dp),
        .i_onOff(onOff), .o_digitPosition(oPos), .o_fndFont(oFont), .o_frameTick(oTick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] refFont(input logic [15:0] v, input logic [3:0] d, input int dig);
        int nib;
        logic [7:0] f;
        nib = (v >> (4 * dig)) & 15;
        if (dig > 0 && (v >> (4 * dig)) == 0) f = 8'hFF;
        else if (nib > 9) f = 8'hBF;
        else f = lut[nib];
        if (d[dig]) f = f & 8'h7F;
        return f;
    endfunction

    // One clock edge; the model applies the same inputs the DUT saw at that edge.
    task automatic step();
        int pos;
        int dig;
        @(posedge clk);
        if (!rstN) begin
            mVal = 0; mDp = 0; k = 0;
            expPos = 4'b1111; expFont = 8'hFF; expTick = 1'b0;
        end else begin
            if (!onOff) begin
                k = 0;
                expPos = 4'b1111; expFont = 8'hFF; expTick = 1'b0;
            end else begin
                pos = k % 10;
                dig = (k / 10) % 4;
                if (pos == 1) begin
                    sVal = mVal;
                    sDp  = mDp;
                end
                if (pos < 2) begin
                    expPos = 4'b1111; expFont = 8'hFF;
                end else begin
                    expPos  = ~(4'b0001 << dig);
                    expFont = refFont(sVal, sDp, dig);
                end
                expTick = (k % 40 == 39);
                k++;
            end
            if (load) begin
                mVal = value;
                mDp  = dp;
            end
        end
        #1;
    endtask

    task automatic runChecked(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            step();
            nCmp++;
            if (oPos !== expPos || oFont !== expFont || oTick !== expTick) begin
                nErr++;
                $display("FAIL %s c=%0d got %b/%h/%b expected %b/%h/%b",
                         tag, c, oPos, oFont, oTick, expPos, expFont, expTick);
            end
        end
    endtask

    // Advance (with checks) until the next edge will be seen at scan position target of the frame.
    task automatic runUntil(input int target, input string tag);
        int n;
        n = 0;
        while (k % 40 != target && n < 45) begin
            runChecked(1, tag);
            n++;
        end
        nCmp++;
        if (k % 40 != target) begin
            nErr++;
            $display("FAIL %s_wait got pos %0d expected %0d", tag, k % 40, target);
        end
    endtask

    task automatic loadValue(input logic [15:0] v, input logic [3:0] d);
        value = v; dp = d; load = 1'b1;
        runChecked(1, "load");
        load = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0; load = 1'b0; value = 16'h5678; dp = 4'hF; onOff = 1'b1;
        step(); step();
        nCmp++;
        if (oPos !== 4'b1111) begin nErr++; $display("FAIL reset_pos got %b expected 1111", oPos); end
        nCmp++;
        if (oFont !== 8'hFF) begin nErr++; $display("FAIL reset_font got %h expected FF", oFont); end
        nCmp++;
        if (oTick !== 1'b0) begin nErr++; $display("FAIL reset_tick got %b expected 0", oTick); end
        rstN = 1'b1;
    endtask

    task automatic test_scan();
        loadValue(16'h1234, 4'b0000);
        runChecked(120, "scan1234");
        runUntil(5, "scan1234");
        runChecked(1, "scan1234");
        nCmp++;
        if (oPos !== 4'b1110 || oFont !== 8'h99) begin
            nErr++; $display("FAIL scan_digit0 got %b/%h expected 1110/99", oPos, oFont);
        end
        runUntil(33, "scan1234");
        runChecked(1, "scan1234");
        nCmp++;
        if (oPos !== 4'b0111 || oFont !== 8'hF9) begin
            nErr++; $display("FAIL scan_digit3 got %b/%h expected 0111/F9", oPos, oFont);
        end
    endtask

    task automatic test_lz_blank();
        loadValue(16'h0007, 4'b0000);
        runChecked(80, "lz0007");
        runUntil(15, "lz0007");
        runChecked(1, "lz0007");
        nCmp++;
        if (oPos !== 4'b1101 || oFont !== 8'hFF) begin
            nErr++; $display("FAIL lz_digit1 got %b/%h expected 1101/FF", oPos, oFont);
        end
        loadValue(16'h0070, 4'b0000);
        runChecked(80, "lz0070");
        loadValue(16'h00A5, 4'b0010);
        runChecked(80, "lz00A5");
        runUntil(15, "lz00A5");
        runChecked(1, "lz00A5");
        nCmp++;
        if (oFont !== 8'h3F) begin
            nErr++; $display("FAIL dash_dp got %h expected 3F", oFont);
        end
    endtask

    task automatic test_mid_load();
        runUntil(5, "midload");
        loadValue(16'h9999, 4'b0000);
        runChecked(1, "midload");
        nCmp++;
        if (oPos !== 4'b1110 || oFont !== 8'h92) begin
            nErr++; $display("FAIL midload_old got %b/%h expected 1110/92", oPos, oFont);
        end
        runChecked(6, "midload");
        nCmp++;
        if (oPos !== 4'b1101 || oFont !== 8'h90) begin
            nErr++; $display("FAIL midload_new got %b/%h expected 1101/90", oPos, oFont);
        end
        runChecked(50, "midload");
    endtask

    task automatic test_on_off();
        runUntil(25, "onoff");
        onOff = 1'b0;
        runChecked(1, "onoff");
        nCmp++;
        if (oPos !== 4'b1111 || oFont !== 8'hFF || oTick !== 1'b0) begin
            nErr++; $display("FAIL off_dark got %b/%h/%b expected 1111/FF/0", oPos, oFont, oTick);
        end
        loadValue(16'h4321, 4'b1000);
        runChecked(5, "off");
        onOff = 1'b1;
        runChecked(2, "reon");
        nCmp++;
        if (oPos !== 4'b1111) begin
            nErr++; $display("FAIL reon_blank got %b expected 1111", oPos);
        end
        runChecked(1, "reon");
        nCmp++;
        if (oPos !== 4'b1110 || oFont !== 8'hF9) begin
            nErr++; $display("FAIL reon_digit0 got %b/%h expected 1110/F9", oPos, oFont);
        end
        runChecked(60, "reon");
    endtask

    task automatic test_reset_mid_scan();
        runUntil(15, "rstmid");
        rstN = 1'b0; load = 1'b1; value = 16'h8888; dp = 4'hF;
        runChecked(1, "rstmid");
        nCmp++;
        if (oPos !== 4'b1111 || oFont !== 8'hFF) begin
            nErr++; $display("FAIL rstmid_dark got %b/%h expected 1111/FF", oPos, oFont);
        end
        rstN = 1'b1; load = 1'b0; onOff = 1'b1;
        runChecked(3, "rstmid");
        nCmp++;
        if (oPos !== 4'b1110 || oFont !== 8'hC0) begin
            nErr++; $display("FAIL rstmid_zero got %b/%h expected 1110/C0", oPos, oFont);
        end
        runChecked(40, "rstmid");
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            load = ($urandom_range(0, 24) == 0);
            if (load) begin
                value = 16'($urandom);
                if ($urandom_range(0, 1) == 1) value = value & 16'h00FF;
                dp = 4'($urandom);
            end
            if (onOff && $urandom_range(0, 299) == 0) onOff = 1'b0;
            else if (!onOff && $urandom_range(0, 7) == 0) onOff = 1'b1;
            rstN = ($urandom_range(0, 999) != 0);
            runChecked(1, "random");
        end
        rstN = 1'b1; load = 1'b0; onOff = 1'b1;
        runChecked(50, "random_tail");
    endtask

    initial begin
        k = 0; mVal = 0; mDp = 0; sVal = 0; sDp = 0;
        expPos = 4'b1111; expFont = 8'hFF; expTick = 1'b0;
        test_reset();
        test_scan();
        test_lz_blank();
        test_mid_load();
        test_on_off();
        test_reset_mid_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
